// File: rtl/paddle_update_scheduler.sv
// Parses two-byte UART paddle commands and commits them one per cycle after frame start.
// Latency: pending 1 cycle after data byte; P0/P1 strobes at frame_start+1/+2. No backpressure.
// Optional PADDLE_SCHED_ERRCNT_EN adds a saturating o_err_cnt for dropped/aborted commands.
module paddle_update_scheduler #(
    parameter int POS_MAX   = 479,
    parameter int RESET_POS = 240,
    parameter int TIMEOUT   = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_byte,
    input  logic       i_frame_start,
    output logic       o_valid_data,
    output logic [9:0] o_uart_buf,
    output logic       o_player,
    output logic [9:0] o_pos0,
    output logic [9:0] o_pos1,
    output logic       o_busy
`ifdef PADDLE_SCHED_ERRCNT_EN
    ,
    output logic [7:0] o_err_cnt
`endif
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
    localparam logic [9:0] POS_MAX_V = 10'(POS_MAX);
    localparam logic [9:0] RESET_V   = 10'(RESET_POS);

    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_HDR  = 1'b1;
    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_P0    = 2'd1;
    localparam logic [1:0] C_P1    = 2'd2;

    logic [0:0]       rx_state_q, rx_state_d;
    logic             hdr_player_q, hdr_player_d;
    logic [2:0]       hdr_pos_q, hdr_pos_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [1:0][9:0]  pend_pos_q, pend_pos_d;
    logic [1:0]       pend_flag_q, pend_flag_d;
    logic [1:0]       c_state_q, c_state_d;
    logic             valid_q, valid_d;
    logic [9:0]       buf_q, buf_d;
    logic             player_q, player_d;
    logic [1:0][9:0]  pos_q, pos_d;
    logic             busy_q, busy_d;

    logic       is_hdr, is_dat, cmd_done, err_evt;
    logic [9:0] cmd_raw, cmd_pos;
    logic       commit_go, commit_sel;
    logic [1:0] flag_clr;
    logic       unused_hdr_bits;

    assign is_hdr          = i_rx_valid & i_rx_byte[7];
    assign is_dat          = i_rx_valid & ~i_rx_byte[7];
    assign cmd_raw         = {hdr_pos_q, i_rx_byte[6:0]};
    assign cmd_pos         = (cmd_raw > POS_MAX_V) ? POS_MAX_V : cmd_raw;
    assign unused_hdr_bits = ^i_rx_byte[5:3];

    always_comb begin
        rx_state_d   = rx_state_q;
        hdr_player_d = hdr_player_q;
        hdr_pos_d    = hdr_pos_q;
        tmo_d        = tmo_q;
        cmd_done     = 1'b0;
        err_evt      = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (is_hdr) begin
                    hdr_player_d = i_rx_byte[6];
                    hdr_pos_d    = i_rx_byte[2:0];
                    tmo_d        = TMO_LOAD;
                    rx_state_d   = RX_HDR;
                end else if (is_dat) begin
                    err_evt = 1'b1;
                end
            end
            default: begin
                // A byte in the expiry cycle still takes priority over the timeout.
                if (is_hdr) begin
                    hdr_player_d = i_rx_byte[6];
                    hdr_pos_d    = i_rx_byte[2:0];
                    tmo_d        = TMO_LOAD;
                    err_evt      = 1'b1;
                end else if (is_dat) begin
                    cmd_done   = 1'b1;
                    rx_state_d = RX_IDLE;
                end else if (tmo_q == '0) begin
                    err_evt    = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
        endcase
    end

    always_comb begin
        c_state_d  = c_state_q;
        commit_go  = 1'b0;
        commit_sel = 1'b0;
        case (c_state_q)
            C_IDLE: if (i_frame_start) begin
                c_state_d = C_P0;
                commit_go = 1'b1;
            end
            C_P0: begin
                c_state_d  = C_P1;
                commit_go  = 1'b1;
                commit_sel = 1'b1;
            end
            default: c_state_d = C_IDLE;
        endcase

        valid_d  = 1'b0;
        buf_d    = buf_q;
        player_d = player_q;
        pos_d    = pos_q;
        flag_clr = 2'b00;
        if (commit_go && pend_flag_q[commit_sel]) begin
            valid_d             = 1'b1;
            buf_d               = pend_pos_q[commit_sel];
            player_d            = commit_sel;
            pos_d[commit_sel]   = pend_pos_q[commit_sel];
            flag_clr[commit_sel] = 1'b1;
        end
        busy_d = (c_state_d != C_IDLE);

        // Commit reads the old pending value; a same-cycle completion stays pending.
        pend_pos_d  = pend_pos_q;
        pend_flag_d = pend_flag_q & ~flag_clr;
        if (cmd_done) begin
            pend_pos_d[hdr_player_q]  = cmd_pos;
            pend_flag_d[hdr_player_q] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_state_q   <= RX_IDLE;
            hdr_player_q <= 1'b0;
            hdr_pos_q    <= 3'd0;
            tmo_q        <= '0;
            pend_pos_q   <= '0;
            pend_flag_q  <= 2'b00;
            c_state_q    <= C_IDLE;
            valid_q      <= 1'b0;
            buf_q        <= RESET_V;
            player_q     <= 1'b0;
            pos_q        <= {RESET_V, RESET_V};
            busy_q       <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            hdr_player_q <= hdr_player_d;
            hdr_pos_q    <= hdr_pos_d;
            tmo_q        <= tmo_d;
            pend_pos_q   <= pend_pos_d;
            pend_flag_q  <= pend_flag_d;
            c_state_q    <= c_state_d;
            valid_q      <= valid_d;
            buf_q        <= buf_d;
            player_q     <= player_d;
            pos_q        <= pos_d;
            busy_q       <= busy_d;
        end
    end

    assign o_valid_data = valid_q;
    assign o_uart_buf   = buf_q;
    assign o_player     = player_q;
    assign o_pos0       = pos_q[0];
    assign o_pos1       = pos_q[1];
    assign o_busy       = busy_q;

`ifdef PADDLE_SCHED_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    assign err_cnt_d = (err_evt && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) err_cnt_q <= 8'd0;
        else       err_cnt_q <= err_cnt_d;
    end
    assign o_err_cnt = err_cnt_q;
`else
    logic unused_err;
    assign unused_err = err_evt;
`endif

endmodule

// File: tb/tb_paddle_update_scheduler.sv
// Randomized and directed bench for paddle_update_scheduler against a deadline/schedule model.
module tb_paddle_update_scheduler;
    localparam int TIMEOUT = 1024;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_rx_valid = 1'b0;
    logic [7:0] i_rx_byte = 8'h00;
    logic       i_frame_start = 1'b0;
    logic       o_valid_data;
    logic [9:0] o_uart_buf;
    logic       o_player;
    logic [9:0] o_pos0;
    logic [9:0] o_pos1;
    logic       o_busy;
`ifdef PADDLE_SCHED_ERRCNT_EN
    logic [7:0] o_err_cnt;
`endif

    always #5 i_clk = ~i_clk;

    paddle_update_scheduler dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_valid   (i_rx_valid),
        .i_rx_byte    (i_rx_byte),
        .i_frame_start(i_frame_start),
        .o_valid_data (o_valid_data),
        .o_uart_buf   (o_uart_buf),
        .o_player     (o_player),
        .o_pos0       (o_pos0),
        .o_pos1       (o_pos1),
        .o_busy       (o_busy)
`ifdef PADDLE_SCHED_ERRCNT_EN
        ,
        .o_err_cnt    (o_err_cnt)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Reference model: pending table, open header with absolute deadline, frame start time.
    bit m_pend_v[2];
    int m_pend[2];
    bit m_hdr_open;
    bit m_hdr_p;
    int m_hdr_hi;
    int m_deadline;
    bit m_have_frame;
    int m_last_f;
    int m_err;
    bit e_valid;
    int e_buf;
    bit e_player;
    int e_pos[2];
    bit e_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend_v[0] = 0; m_pend_v[1] = 0;
        m_pend[0] = 0;   m_pend[1] = 0;
        m_hdr_open = 0;
        m_have_frame = 0;
        m_last_f = 0;
        m_err = 0;
        e_valid = 0;
        e_buf = 240;
        e_player = 0;
        e_pos[0] = 240; e_pos[1] = 240;
        e_busy = 0;
    endtask

    task automatic model_step(input logic rst, input logic v, input logic [7:0] b, input logic fs);
        int n;
        int val;
        if (rst) begin
            model_reset();
            return;
        end
        e_valid = 0;
        n = -1;
        if (fs && !(m_have_frame && cyc < m_last_f + 3)) begin
            m_have_frame = 1;
            m_last_f = cyc;
            n = 0;
        end else if (m_have_frame && cyc == m_last_f + 1) begin
            n = 1;
        end
        if (n >= 0 && m_pend_v[n]) begin
            e_valid = 1;
            e_buf = m_pend[n];
            e_player = n[0];
            e_pos[n] = m_pend[n];
            m_pend_v[n] = 0;
        end
        if (v) begin
            if (b[7]) begin
                if (m_hdr_open && m_err < 255) m_err++;
                m_hdr_open = 1;
                m_hdr_p = b[6];
                m_hdr_hi = int'(b[2:0]);
                m_deadline = cyc + TIMEOUT;
            end else if (m_hdr_open) begin
                val = m_hdr_hi * 128 + int'(b[6:0]);
                if (val > 479) val = 479;
                m_pend[m_hdr_p] = val;
                m_pend_v[m_hdr_p] = 1;
                m_hdr_open = 0;
            end else if (m_err < 255) begin
                m_err++;
            end
        end
        if (m_hdr_open && cyc == m_deadline) begin
            m_hdr_open = 0;
            if (m_err < 255) m_err++;
        end
        e_busy = m_have_frame && (cyc == m_last_f || cyc == m_last_f + 1);
    endtask

    task automatic cycle(input logic rst, input logic v, input logic [7:0] b, input logic fs);
        i_rst = rst;
        i_rx_valid = v;
        i_rx_byte = b;
        i_frame_start = fs;
        model_step(rst, v, b, fs);
        @(posedge i_clk);
        #1;
        check("valid", 32'(o_valid_data), 32'(e_valid));
        check("player", 32'(o_player), 32'(e_player));
        check("uart_buf", 32'(o_uart_buf), e_buf);
        check("pos0", 32'(o_pos0), e_pos[0]);
        check("pos1", 32'(o_pos1), e_pos[1]);
        check("busy", 32'(o_busy), 32'(e_busy));
`ifdef PADDLE_SCHED_ERRCNT_EN
        check("err_cnt", 32'(o_err_cnt), m_err);
`endif
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] hdr, input logic [7:0] dat);
        cycle(1'b0, 1'b1, hdr, 1'b0);
        cycle(1'b0, 1'b1, dat, 1'b0);
    endtask

    task automatic frame();
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [7:0] rb;
        model_reset();
        @(posedge i_clk);
        #1;

        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_pos0", 32'(o_pos0), 240);
        check("rst_buf", 32'(o_uart_buf), 240);
        check("rst_busy", 32'(o_busy), 0);

        // Player 1 to 172: only the second commit slot strobes.
        send(8'hC1, 8'h2C);
        idle(2);
        frame();
        check("t1_no_p0", 32'(o_valid_data), 0);
        idle(1);
        check("t1_vld", 32'(o_valid_data), 1);
        check("t1_player", 32'(o_player), 1);
        check("t1_buf", 32'(o_uart_buf), 172);
        check("t1_pos0", 32'(o_pos0), 240);
        idle(3);

        send(8'h80, 8'h64);
        send(8'hC2, 8'h2C);
        frame();
        check("t2_p0_buf", 32'(o_uart_buf), 100);
        check("t2_p0_ply", 32'(o_player), 0);
        idle(1);
        check("t2_p1_buf", 32'(o_uart_buf), 300);
        check("t2_p1_ply", 32'(o_player), 1);
        idle(2);
        frame();
        check("t2_rep_p0", 32'(o_valid_data), 0);
        idle(1);
        check("t2_rep_p1", 32'(o_valid_data), 0);
        idle(2);

        send(8'h87, 8'h7F);
        frame();
        check("t3_clamp", 32'(o_uart_buf), 479);
        idle(3);

        // Header left open past its deadline; the late data byte is an error.
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h81, 1'b0);
        idle(TIMEOUT);
        cycle(1'b0, 1'b1, 8'h05, 1'b0);
        frame();
        check("t4_no_p0", 32'(o_valid_data), 0);
        idle(1);
        check("t4_no_p1", 32'(o_valid_data), 0);
        check("t4_pos1", 32'(o_pos1), 240);
`ifdef PADDLE_SCHED_ERRCNT_EN
        check("t4_errcnt", 32'(o_err_cnt), 2);
`endif
        idle(2);

        send(8'h80, 8'h64);
        cycle(1'b0, 1'b1, 8'h80, 1'b0);
        frame();
        check("t5_old", 32'(o_uart_buf), 100);
        cycle(1'b0, 1'b1, 8'h32, 1'b0);
        idle(3);
        frame();
        check("t5_new", 32'(o_uart_buf), 50);
        idle(3);
        send(8'h80, 8'h0A);
        cycle(1'b0, 1'b1, 8'h80, 1'b0);
        cycle(1'b0, 1'b1, 8'h14, 1'b1);
        check("t5_same_old", 32'(o_uart_buf), 10);
        idle(3);
        frame();
        check("t5_same_new", 32'(o_uart_buf), 20);
        idle(3);

        send(8'h80, 8'h64);
        send(8'hC2, 8'h2C);
        frame();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("t6_vld", 32'(o_valid_data), 0);
        check("t6_pos0", 32'(o_pos0), 240);
        check("t6_pos1", 32'(o_pos1), 240);
        idle(2);

        repeat (4000) begin
            rb = {($urandom_range(0, 2) == 0), 7'($urandom_range(0, 127))};
            cycle($urandom_range(0, 999) < 4, $urandom_range(0, 99) < 45, rb,
                  $urandom_range(0, 99) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/paddle_update_scheduler.md
# paddle_update_scheduler

Sequences paddle-position updates from the UART receiver into the render path of the pong design. It parses two-byte position commands per player and holds the latest one per paddle. At each frame start it commits pending positions one per cycle over a single shared update port, so the downstream double-flop synchronizer and renderer never see a mid-frame change.

## Interface
- `POS_MAX`, 479: largest legal paddle position. Larger received values are clamped to it.
- `RESET_POS`, 240: value of both paddle positions after reset.
- `TIMEOUT`, 1024: cycles allowed between header and data byte before the command is dropped.
- `i_clk`, in, 1: system clock. This is the only clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_rx_valid`, in, 1: one-cycle strobe; `i_rx_byte` is valid.
- `i_rx_byte`, in, 8: received UART byte.
- `i_frame_start`, in, 1: one-cycle pulse at the start of vertical blanking.
- `o_valid_data`, out, 1: one-cycle update strobe to the synchronizer.
- `o_uart_buf`, out, 10: committed position; valid with `o_valid_data`.
- `o_player`, out, 1: paddle index for the current update.
- `o_pos0`, out, 10: current committed position of paddle 0.
- `o_pos1`, out, 10: current committed position of paddle 1.
- `o_busy`, out, 1: high while the commit FSM is not idle.

## Operation
- Byte protocol:
  - Header byte: bit7=1, bit6=player, bits5:3 ignored, bits2:0 = pos[9:7].
  - Data byte: bit7=0, bits6:0 = pos[6:0].
- Receive FSM states are `RX_IDLE` and `RX_HDR`.
  - In `RX_IDLE`, a header stores player and pos[9:7], loads the timeout counter, and moves to `RX_HDR`. A data byte is dropped as an error.
  - In `RX_HDR`, a data byte completes the command and returns to `RX_IDLE`. A header restarts the command with the new header and stays in `RX_HDR`. A timeout expiry returns to `RX_IDLE` with no update.
- Completed command:
  - pos = {hdr[2:0], data[6:0]}, clamped to `POS_MAX` with an unsigned compare.
  - The result is written into `pend_pos[player]` and `pend_flag[player]` is set.
  - Latest command wins: a newer command overwrites an uncommitted one.
- Commit FSM states are `C_IDLE`, `C_P0` and `C_P1`.
  - `i_frame_start` in `C_IDLE` moves to `C_P0`.
  - `C_P0` goes to `C_P1`. `C_P1` goes to `C_IDLE`.
  - In `C_Pn`, if `pend_flag[n]` is set: pulse `o_valid_data`, drive `o_uart_buf = pend_pos[n]` and `o_player = n`, load `o_posn`, clear `pend_flag[n]`.
  - If `pend_flag[n]` is clear in `C_Pn`, no strobe is issued and outputs hold.
- `i_frame_start` outside `C_IDLE` is ignored.
- Simultaneous completion and commit of the same player in the same cycle: the commit uses the old pending value, and the new value stays pending with its flag set for the next frame.
- Reset:
  - Both FSMs go idle, pending flags clear, and the timeout counter is zeroed.
  - `o_pos0 = o_pos1 = o_uart_buf = RESET_POS`.
  - `o_valid_data`, `o_player` and `o_busy` go to 0.
  - Reset mid-command or mid-commit discards all partial and pending state.

## Timing
- Command completion: the data byte strobe at cycle m makes the pending value visible at m+1.
- `i_frame_start` at cycle f: P0 update strobe at f+1, P1 at f+2, back in `C_IDLE` at f+3.
- `o_busy` is high during f+1 and f+2.
- All outputs are registered; `o_posn` changes in the same cycle as its strobe.
- Timeout: the counter loads `TIMEOUT-1` on a header and decrements each cycle in `RX_HDR`. At 0 with no byte that cycle, the FSM returns to `RX_IDLE` on the next edge. A data byte arriving in the expiry cycle still completes the command.
- Back-to-back `i_rx_valid` every cycle is supported.

## Configuration
- `PADDLE_SCHED_ERRCNT_EN` defined:
  - Adds output `o_err_cnt[7:0]`, reset 0.
  - Increments once per dropped data byte in `RX_IDLE`, per header restart, and per timeout.
  - Saturates at 255.
- Not defined: the port and counter are absent, and errors are silently dropped.

## Test plan
- Reset, then bytes 0xC1 and 0x2C (player1, pos 172), then frame_start at f: strobe at f+2 with `o_player`=1 and `o_uart_buf`=172; no strobe at f+1; `o_pos0` stays 240.
- Commands for P0=100 and P1=300, then frame_start: strobes at f+1 (0,100) and f+2 (1,300); a second frame_start gives no strobes.
- Header 0x87 with data 0x7F (1023): committed value is 479.
- Header with no data for 1024 cycles, then data 0x05: no pending update, and the error count increments by 2 when enabled.
- The data byte completing a P0 command lands in the `C_P0` cycle: the old value is committed, and the new value commits at the next frame_start.
- Reset asserted during `C_P0`: no strobe follows, and positions return to 240.
